// File: rtl/banderin_pkg.sv
// rtl/banderin_pkg.sv - shared state encoding and timing helpers for the flag sequencer
package banderin_pkg;

  typedef enum logic [1:0] {
    ABAJO    = 2'd0,
    SUBIENDO = 2'd1,
    ARRIBA   = 2'd2,
    BAJANDO  = 2'd3
  } banderin_state_e;

  // Divide before multiplying so large clock rates do not overflow 32 bits.
  function automatic longint unsigned ms_to_clks(input longint unsigned freq_hz,
                                                 input longint unsigned ms);
    return (freq_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/banderin_timer.sv
// rtl/banderin_timer.sv - clearable up-counter with terminal-count flag, shared by settle and hold
module banderin_timer #(
  parameter int TIMER_BITS = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [TIMER_BITS-1:0] load,
  output logic                  tc
);

  logic [TIMER_BITS-1:0] count_q, count_d;

  // Next count: clear has priority over counting; never wraps in use.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + TIMER_BITS'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == load);

endmodule

// File: rtl/banderin_ctrl.sv
// rtl/banderin_ctrl.sv - flag servo sequencer; BANDERIN_AUTO_BAJAR_EN enables auto-lower after hold
module banderin_ctrl
  import banderin_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 25_000_000,
  parameter int unsigned SETTLE_MS   = 300,
  parameter int unsigned HOLD_MS     = 2000,
  parameter int          TIMER_BITS  = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_subir,
  input  logic       req_bajar,
  output logic       comando_banderin,
  output logic       busy,
  output logic       en_posicion,
  output logic       done,
  output logic [1:0] estado
);

  localparam longint unsigned SETTLE_CLKS = ms_to_clks(CLK_FREQ_HZ, SETTLE_MS);
  localparam longint unsigned HOLD_CLKS   = ms_to_clks(CLK_FREQ_HZ, HOLD_MS);
  localparam longint unsigned TIMER_MAX   = (64'd1 << TIMER_BITS) - 64'd1;
  localparam logic [TIMER_BITS-1:0] SETTLE_LOAD = TIMER_BITS'(SETTLE_CLKS - 64'd1);

  if (SETTLE_CLKS > TIMER_MAX || HOLD_CLKS > TIMER_MAX) begin : g_timer_too_small
    $error("banderin_ctrl: TIMER_BITS too small for settle/hold count");
  end

  banderin_state_e state_q, state_d;
  logic pending_q, pending_d;
  logic comando_q, comando_d;
  logic busy_q, busy_d;
  logic en_pos_q, en_pos_d;
  logic done_q, done_d;
  logic settled;
  logic timer_clr, timer_en, timer_tc;
  logic [TIMER_BITS-1:0] timer_load;

`ifdef BANDERIN_AUTO_BAJAR_EN
  localparam logic [TIMER_BITS-1:0] HOLD_LOAD = TIMER_BITS'(HOLD_CLKS - 64'd1);
  assign timer_load = (state_q == ARRIBA) ? HOLD_LOAD : SETTLE_LOAD;
`else
  assign timer_load = SETTLE_LOAD;
`endif

  banderin_timer #(.TIMER_BITS(TIMER_BITS)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clr),
    .enable (timer_en),
    .load   (timer_load),
    .tc     (timer_tc)
  );

  // State, pending-reversal and registered outputs; reset drives the flag down.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= BAJANDO;
      pending_q <= 1'b0;
      comando_q <= 1'b0;
      busy_q    <= 1'b1;
      en_pos_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      comando_q <= comando_d;
      busy_q    <= busy_d;
      en_pos_q  <= en_pos_d;
      done_q    <= done_d;
    end
  end

  // Next state, pending reversal and timer control.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    settled   = 1'b0;
    case (state_q)
      ABAJO: begin
        if (req_subir && !req_bajar) state_d = SUBIENDO;
      end
      SUBIENDO: begin
        timer_en = 1'b1;
        if (req_bajar && !req_subir) pending_d = 1'b1;
        else if (req_subir && !req_bajar) pending_d = 1'b0;
        if (timer_tc) begin
          if (pending_d) begin
            state_d = BAJANDO;
          end else begin
            state_d = ARRIBA;
            settled = 1'b1;
          end
        end
      end
      ARRIBA: begin
`ifdef BANDERIN_AUTO_BAJAR_EN
        timer_en = 1'b1;
        if (req_bajar) state_d = BAJANDO;
        else if (req_subir) timer_clr = 1'b1;
        else if (timer_tc) state_d = BAJANDO;
`else
        if (req_bajar) state_d = BAJANDO;
        else if (req_subir) timer_clr = 1'b1;
`endif
      end
      BAJANDO: begin
        timer_en = 1'b1;
        if (req_subir && !req_bajar) pending_d = 1'b1;
        else if (req_bajar && !req_subir) pending_d = 1'b0;
        if (timer_tc) begin
          if (pending_d) begin
            state_d = SUBIENDO;
          end else begin
            state_d = ABAJO;
            settled = 1'b1;
          end
        end
      end
      default: state_d = BAJANDO;
    endcase
    // Any transition starts the new state with a fresh timer and no queued reversal.
    if (state_d != state_q) begin
      timer_clr = 1'b1;
      pending_d = 1'b0;
    end
  end

  // Output decode from the next state so the outputs can be registered.
  always_comb begin
    comando_d = (state_d == SUBIENDO) || (state_d == ARRIBA);
    busy_d    = (state_d == SUBIENDO) || (state_d == BAJANDO);
    en_pos_d  = (state_d == ABAJO) || (state_d == ARRIBA);
    done_d    = settled;
  end

  assign comando_banderin = comando_q;
  assign busy             = busy_q;
  assign en_posicion      = en_pos_q;
  assign done             = done_q;
  assign estado           = state_q;

endmodule

// File: tb/tb_banderin_ctrl.sv
// tb/tb_banderin_ctrl.sv - scoreboard bench for banderin_ctrl (1 clk/ms, settle 5, hold 20)
module tb_banderin_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_subir = 1'b0;
  logic       req_bajar = 1'b0;
  logic       comando_banderin;
  logic       busy;
  logic       en_posicion;
  logic       done;
  logic [1:0] estado;

  banderin_ctrl #(
    .CLK_FREQ_HZ (1000),
    .SETTLE_MS   (5),
    .HOLD_MS     (20),
    .TIMER_BITS  (26)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_subir        (req_subir),
    .req_bajar        (req_bajar),
    .comando_banderin (comando_banderin),
    .busy             (busy),
    .en_posicion      (en_posicion),
    .done             (done),
    .estado           (estado)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] estado;
    logic       cmd;
    logic       busy;
    logic       enpos;
    logic       done;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   errors = 0;
  logic flush = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare DUT outputs against every expectation due this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && (flush || exp_q[0].cyc <= cyc)) begin
      e = exp_q.pop_front();
      tests = tests + 1;
      if (e.cyc != cyc) begin
        errors = errors + 1;
        $display("FAIL %s: check for cycle %0d not performed (now cycle %0d)", e.name, e.cyc, cyc);
      end else if (estado !== e.estado || comando_banderin !== e.cmd || busy !== e.busy ||
                   en_posicion !== e.enpos || done !== e.done) begin
        errors = errors + 1;
        $display("FAIL %s @%0d: got estado=%0d cmd=%b busy=%b enpos=%b done=%b, expected estado=%0d cmd=%b busy=%b enpos=%b done=%b",
                 e.name, cyc, estado, comando_banderin, busy, en_posicion, done,
                 e.estado, e.cmd, e.busy, e.enpos, e.done);
      end
    end
  end

  task automatic expect_at(input int k, input logic [1:0] es, input logic c, input logic b,
                           input logic p, input logic d, input string n);
    exp_t e;
    e.cyc = cyc + k; e.estado = es; e.cmd = c; e.busy = b; e.enpos = p; e.done = d; e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic wait_edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic s, input logic b);
    req_subir = s;
    req_bajar = b;
    @(posedge clk);
    #1;
    req_subir = 1'b0;
    req_bajar = 1'b0;
  endtask

  initial begin
    wait_edges(3);
    // 1: reset state, then settle down into ABAJO
    expect_at(0, 2'd3, 0, 1, 0, 0, "reset_state");
    reset = 1'b0;
    expect_at(4, 2'd3, 0, 1, 0, 0, "reset_settle_busy");
    expect_at(5, 2'd0, 0, 0, 1, 1, "reset_done");
    expect_at(6, 2'd0, 0, 0, 1, 0, "reset_done_one_cycle");
    wait_edges(6);

    // 2: raise from ABAJO
    pulse(1, 0);
    expect_at(0, 2'd1, 1, 1, 0, 0, "subir_start");
    expect_at(4, 2'd1, 1, 1, 0, 0, "subir_last_settle");
    expect_at(5, 2'd2, 1, 0, 1, 1, "subir_done");
    expect_at(6, 2'd2, 1, 0, 1, 0, "arriba_rest");
    wait_edges(6);

    // 5b: both requests in ARRIBA -> lower wins
    pulse(1, 1);
    expect_at(0, 2'd3, 0, 1, 0, 0, "arriba_both_lower");
    expect_at(5, 2'd0, 0, 0, 1, 1, "arriba_both_abajo");
    wait_edges(5);

    // 5a: both requests in ABAJO -> no change, no done
    pulse(1, 1);
    expect_at(0, 2'd0, 0, 0, 1, 0, "abajo_both_noop");
    expect_at(1, 2'd0, 0, 0, 1, 0, "abajo_both_still");
    wait_edges(1);

    // 3: reversal queued mid-raise
    pulse(1, 0);
    expect_at(0, 2'd1, 1, 1, 0, 0, "rev_subir_start");
    wait_edges(2);
    pulse(0, 1);
    expect_at(0, 2'd1, 1, 1, 0, 0, "rev_cmd_still_up");
    expect_at(1, 2'd1, 1, 1, 0, 0, "rev_cmd_last");
    expect_at(2, 2'd3, 0, 1, 0, 0, "rev_to_bajando_nodone");
    expect_at(6, 2'd3, 0, 1, 0, 0, "rev_bajando_last");
    expect_at(7, 2'd0, 0, 0, 1, 1, "rev_abajo_done");
    wait_edges(7);

    // 4: ARRIBA idle behaviour
    pulse(1, 0);
    expect_at(5, 2'd2, 1, 0, 1, 1, "hold_enter");
    wait_edges(5);
`ifdef BANDERIN_AUTO_BAJAR_EN
    expect_at(19, 2'd2, 1, 0, 1, 0, "hold_before_drop");
    expect_at(20, 2'd3, 0, 1, 0, 0, "hold_auto_drop");
    expect_at(25, 2'd0, 0, 0, 1, 1, "hold_drop_abajo");
    wait_edges(25);
    pulse(1, 0);
    expect_at(5, 2'd2, 1, 0, 1, 1, "rearm_enter");
    wait_edges(5);
    wait_edges(15);
    pulse(1, 0);
    expect_at(0, 2'd2, 1, 0, 1, 0, "rearm_stay");
    expect_at(19, 2'd2, 1, 0, 1, 0, "rearm_before_drop");
    expect_at(20, 2'd3, 0, 1, 0, 0, "rearm_drop");
    expect_at(25, 2'd0, 0, 0, 1, 1, "rearm_abajo");
    wait_edges(25);
`else
    expect_at(100, 2'd2, 1, 0, 1, 0, "hold_forever");
    wait_edges(100);
    pulse(0, 1);
    expect_at(0, 2'd3, 0, 1, 0, 0, "hold_manual_lower");
    expect_at(5, 2'd0, 0, 0, 1, 1, "hold_manual_abajo");
    wait_edges(5);
`endif

    // 6: reset mid-raise with a queued reversal
    pulse(1, 0);
    pulse(0, 1);
    wait_edges(1);
    reset = 1'b1;
    req_subir = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_subir = 1'b0;
    expect_at(0, 2'd3, 0, 1, 0, 0, "midreset_bajando");
    expect_at(4, 2'd3, 0, 1, 0, 0, "midreset_settle");
    expect_at(5, 2'd0, 0, 0, 1, 1, "midreset_abajo_no_pending");
    wait_edges(6);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
